delta_decoder_with_feedback: RTL and testbench



---
 rtl/delta_codec_pkg.sv | 8 +
 rtl/skid_buffer_2.sv | 57 +++++
 rtl/delta_decoder_with_feedback.sv | 44 ++++
 tb/tb_delta_decoder_with_feedback.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/delta_codec_pkg.sv
// delta_codec_pkg: shared constants, buffer state encoding and modular subtract for the delta codec.
package delta_codec_pkg;
  localparam int DATA_WIDTH = 16;
  typedef enum logic [1:0] {EMPTY, ONE, TWO} buf_state_t;
  function automatic logic [DATA_WIDTH-1:0] mod_sub(input logic [DATA_WIDTH-1:0] a, input logic [DATA_WIDTH-1:0] b);
    return a - b;
  endfunction
endpackage

// File: rtl/skid_buffer_2.sv
// skid_buffer_2: two-entry FIFO skid buffer with registered in_ready; output driven from the main entry only.
module skid_buffer_2
  import delta_codec_pkg::*;
#(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] in_data,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [W-1:0] out_data,
  output logic         out_valid,
  input  logic         out_ready
);
  buf_state_t state, next;
  logic [W-1:0] main_q, skid_q, main_d, skid_d;
  logic accept, xfer;
  assign accept = in_valid & in_ready;
  assign xfer = out_valid & out_ready;
  assign out_valid = state != EMPTY;
  assign out_data = main_q;
  always_comb begin
    next = state;
    main_d = main_q;
    skid_d = skid_q;
    case (state)
      EMPTY: begin
        next = accept ? ONE : EMPTY;
        main_d = accept ? in_data : main_q;
      end
      ONE: begin
        next = (accept && !xfer) ? TWO : (xfer && !accept) ? EMPTY : ONE;
        main_d = (accept && xfer) ? in_data : main_q;
        skid_d = (accept && !xfer) ? in_data : skid_q;
      end
      TWO: begin
        next = xfer ? ONE : TWO;
        main_d = xfer ? skid_q : main_q;
      end
      default: next = EMPTY;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      in_ready <= 1'b1;
    end else begin
      state <= next;
      main_q <= main_d;
      skid_q <= skid_d;
      in_ready <= next != TWO;
    end
  end
endmodule

// File: rtl/delta_decoder_with_feedback.sv
// delta_decoder_with_feedback: recovers x[n] = y[n] - y[n-1] from an accumulated stream, with flow control.
module delta_decoder_with_feedback
  import delta_codec_pkg::*;
#(
  parameter int WIDTH = DATA_WIDTH,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WIDTH-1:0]     in,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic                 restart,
  output logic [WIDTH-1:0]     out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [CNT_WIDTH-1:0] sample_count
);
  logic [WIDTH-1:0] prev, base, d;
  logic accept;
  assign accept = in_valid & in_ready;
  // restart zeroes the history in the same cycle, so a coincident sample decodes against 0
  assign base = restart ? '0 : prev;
  assign d = in - base;
  always_ff @(posedge clk) begin
    if (reset) begin
      prev <= '0;
      sample_count <= '0;
    end else begin
      prev <= accept ? in : base;
      sample_count <= (restart ? '0 : sample_count) + CNT_WIDTH'(accept);
    end
  end
  skid_buffer_2 #(.W(WIDTH)) u_buf (
    .clk(clk),
    .reset(reset),
    .in_data(d),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .out_data(out),
    .out_valid(out_valid),
    .out_ready(out_ready)
  );
endmodule

// File: tb/tb_delta_decoder_with_feedback.sv
// tb_delta_decoder_with_feedback: vector table, hand sequences and a scoreboard checking every output transfer.
module tb_delta_decoder_with_feedback;
  import delta_codec_pkg::*;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic in_valid = 1'b0;
  logic restart = 1'b0;
  logic out_ready = 1'b0;
  logic [15:0] in = '0;
  logic [15:0] out, sample_count;
  logic in_ready, out_valid;
  int compared = 0;
  int mismatched = 0;
  logic [15:0] exp_q[$];
  logic [15:0] x_q[$];
  logic [15:0] m_prev = '0;
  logic [15:0] m_cnt = '0;
  logic [15:0] e, cur_x, acc;
  bit e2e = 1'b0;
  int rcv = 0;
  int sent;
  typedef struct packed {
    logic [15:0] y;
    logic        rs;
    logic [15:0] x;
    logic [15:0] cnt;
  } vec_t;
  vec_t vecs[10];

  delta_decoder_with_feedback dut (
    .clk(clk),
    .reset(reset),
    .in(in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .restart(restart),
    .out(out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sample_count(sample_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    in_valid = 1'b0;
    restart = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  // Scoreboard: expected values enter at accept and leave at output transfer.
  always @(negedge clk) begin
    if (reset) begin
      exp_q.delete();
      x_q.delete();
      m_prev = '0;
      m_cnt = '0;
    end else begin
      check("sample_count", sample_count, m_cnt);
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_out: got %h with no sample pending", out);
        end else begin
          e = exp_q.pop_front();
          check("sb_out", out, e);
        end
        if (e2e && x_q.size() != 0) begin
          e = x_q.pop_front();
          check("e2e_out", out, e);
          rcv++;
        end
      end
      if (in_valid && in_ready) begin
        exp_q.push_back(mod_sub(in, restart ? 16'd0 : m_prev));
        if (e2e) x_q.push_back(cur_x);
        m_prev = in;
        m_cnt = restart ? 16'd1 : m_cnt + 16'd1;
      end else if (restart) begin
        m_prev = '0;
        m_cnt = '0;
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{16'd5, 1'b0, 16'd5, 16'd1};
    vecs[1] = '{16'd12, 1'b0, 16'd7, 16'd2};
    vecs[2] = '{16'd12, 1'b0, 16'd0, 16'd3};
    vecs[3] = '{16'd20, 1'b0, 16'd8, 16'd4};
    vecs[4] = '{16'hFFF0, 1'b1, 16'hFFF0, 16'd1};
    vecs[5] = '{16'h0010, 1'b0, 16'h0020, 16'd2};
    vecs[6] = '{16'd10, 1'b1, 16'd10, 16'd1};
    vecs[7] = '{16'd15, 1'b0, 16'd5, 16'd2};
    vecs[8] = '{16'd4, 1'b1, 16'd4, 16'd1};
    vecs[9] = '{16'd6, 1'b0, 16'd2, 16'd2};
    repeat (3) tick();
    check("rst_out", out, 16'd0);
    check("rst_out_valid", 16'(out_valid), 16'd0);
    check("rst_in_ready", 16'(in_ready), 16'd1);
    check("rst_count", sample_count, 16'd0);
    reset = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      in = vecs[i].y;
      restart = vecs[i].rs;
      in_valid = 1'b1;
      tick();
      check($sformatf("vec%0d_out", i), out, vecs[i].x);
      check($sformatf("vec%0d_valid", i), 16'(out_valid), 16'd1);
      check($sformatf("vec%0d_count", i), sample_count, vecs[i].cnt);
    end
    in_valid = 1'b0;
    restart = 1'b0;
    tick();
    check("drained_valid", 16'(out_valid), 16'd0);
    restart = 1'b1;
    tick();
    check("restart_alone_count", sample_count, 16'd0);
    restart = 1'b0;
    in = 16'd7;
    in_valid = 1'b1;
    tick();
    check("restart_alone_out", out, 16'd7);
    check("restart_alone_count1", sample_count, 16'd1);
    in_valid = 1'b0;
    tick();

    do_reset();
    out_ready = 1'b0;
    in = 16'd3;
    in_valid = 1'b1;
    tick();
    check("bp_ready1", 16'(in_ready), 16'd1);
    check("bp_out1", out, 16'd3);
    in = 16'd4;
    tick();
    check("bp_ready_full", 16'(in_ready), 16'd0);
    check("bp_hold1", out, 16'd3);
    in = 16'd9;
    tick();
    check("bp_hold2", out, 16'd3);
    check("bp_count2", sample_count, 16'd2);
    out_ready = 1'b1;
    tick();
    check("bp_drain1", out, 16'd1);
    check("bp_ready_back", 16'(in_ready), 16'd1);
    tick();
    check("bp_drain2", out, 16'd5);
    check("bp_count3", sample_count, 16'd3);
    in_valid = 1'b0;
    tick();
    check("bp_empty", 16'(out_valid), 16'd0);

    do_reset();
    out_ready = 1'b0;
    in = 16'd100;
    in_valid = 1'b1;
    tick();
    in = 16'd200;
    tick();
    check("mid_full", 16'(in_ready), 16'd0);
    in_valid = 1'b0;
    reset = 1'b1;
    tick();
    check("mid_rst_valid", 16'(out_valid), 16'd0);
    check("mid_rst_ready", 16'(in_ready), 16'd1);
    reset = 1'b0;
    in = 16'd7;
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    check("mid_after_out", out, 16'd7);
    check("mid_after_valid", 16'(out_valid), 16'd1);
    in_valid = 1'b0;
    tick();

    // Accumulator modelled here feeds the decoder; output must reproduce x exactly.
    do_reset();
    e2e = 1'b1;
    acc = '0;
    sent = 0;
    while (sent < 100) begin
      cur_x = 16'($urandom);
      in = acc + cur_x;
      in_valid = $urandom_range(0, 3) != 0;
      out_ready = $urandom_range(0, 2) != 0;
      @(negedge clk);
      if (in_valid && in_ready) begin
        acc = in;
        sent++;
      end
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    for (int c = 0; c < 50 && rcv < 100; c++) tick();
    check("e2e_received", 16'(rcv), 16'd100);
    check("e2e_count", sample_count, 16'd100);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
